// File: rtl/i2c_master_ctrl.sv
`timescale 1ns/1ps
// i2c_master_ctrl: single-byte I2C master. One transaction per request:
// START, 7-bit address + R/W, one data byte (write or read), STOP.
// Each bit is four prescaler ticks: q0/q1 SCL low, q2/q3 SCL high.
// SDA changes in q0 and is sampled at the end of q2.
module i2c_master_ctrl #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // LAUNCH holds a captured request until the next tick boundary.
    typedef enum logic [3:0] {
        IDLE, LAUNCH, START, ADDR, ADDR_ACK,
        WRITE_DATA, WRITE_ACK, READ_DATA, READ_NACK, STOP
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [1:0]       q_cnt;
    logic [2:0]       bit_cnt;
    logic             bit_done;
    logic             last_bit;
    logic [7:0]       shift_reg;
    logic [7:0]       data_q;
    logic             rw_q;
    logic             ack_bit;
    logic             scl_out;
    logic             sda_out;
    logic             sda_oe;
    logic             sda_in;

    assign tick     = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_done = tick && (q_cnt == 2'd3);
    assign last_bit = (bit_cnt == 3'd7);
    assign sda_in   = i2c_sda;

    // SCL is never stretched, so the master always drives it.
    assign i2c_scl = scl_out;
    assign i2c_sda = sda_oe ? sda_out : 1'bz;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: advances on bit boundaries.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:       if (enable) state_next = LAUNCH;
            LAUNCH:     if (tick) state_next = START;
            START:      if (bit_done) state_next = ADDR;
            ADDR:       if (bit_done && last_bit) state_next = ADDR_ACK;
            ADDR_ACK:   if (bit_done) begin
                            if (ack_bit)   state_next = STOP;
                            else if (rw_q) state_next = READ_DATA;
                            else           state_next = WRITE_DATA;
                        end
            WRITE_DATA: if (bit_done && last_bit) state_next = WRITE_ACK;
            WRITE_ACK:  if (bit_done) state_next = STOP;
            READ_DATA:  if (bit_done && last_bit) state_next = READ_NACK;
            READ_NACK:  if (bit_done) state_next = STOP;
            STOP:       if (bit_done) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Bus and status outputs decoded from state and quarter-phase.
    always_comb begin
        ready   = 1'b0;
        scl_out = 1'b1;
        sda_out = 1'b1;
        sda_oe  = 1'b1;
        case (state)
            IDLE:       ready = 1'b1;
            LAUNCH:     ;
            START:      sda_out = ~q_cnt[1];
            ADDR, WRITE_DATA: begin
                scl_out = q_cnt[1];
                sda_out = shift_reg[7];
            end
            ADDR_ACK, WRITE_ACK, READ_DATA: begin
                scl_out = q_cnt[1];
                sda_oe  = 1'b0;
            end
            READ_NACK:  scl_out = q_cnt[1];
            STOP: begin
                scl_out = q_cnt[1];
                sda_out = (q_cnt == 2'd3);
            end
            default:    ready = 1'b1;
        endcase
    end

    // Prescaler, bit/quarter counters, request capture and shift datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            q_cnt     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            rw_q      <= 1'b0;
            ack_bit   <= 1'b1;
            data_out  <= 8'h00;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (state == IDLE) begin
                q_cnt   <= '0;
                bit_cnt <= '0;
                if (enable) begin
                    shift_reg <= {addr, rw};
                    data_q    <= data_in;
                    rw_q      <= rw;
                end
            end else if (tick && state != LAUNCH) begin
                q_cnt <= q_cnt + 2'd1;
                if (q_cnt == 2'd2) begin
                    case (state)
                        ADDR_ACK, WRITE_ACK: ack_bit   <= sda_in;
                        READ_DATA:           shift_reg <= {shift_reg[6:0], sda_in};
                        default:             ;
                    endcase
                end
                if (q_cnt == 2'd3) begin
                    case (state)
                        ADDR, WRITE_DATA: begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            bit_cnt   <= bit_cnt + 3'd1;
                        end
                        READ_DATA: bit_cnt <= bit_cnt + 3'd1;
                        ADDR_ACK:  if (!rw_q) shift_reg <= data_q;
                        READ_NACK: data_out <= shift_reg;
                        default:   ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_i2c_master_ctrl.sv
`timescale 1ns/1ps
// tb_i2c_master_ctrl: drives i2c_master_ctrl against a cycle-sampled I2C
// slave at 7'h2A and a transaction-level reference model.
module tb_i2c_master_ctrl;
    localparam int         CLK_DIV    = 2;
    localparam logic [6:0] SLAVE_ADDR = 7'h2A;
    localparam int         TIMEOUT    = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] data_out;
    logic       ready;
    wire        i2c_sda;
    wire        i2c_scl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .enable(enable),
        .rw(rw), .data_out(data_out), .ready(ready),
        .i2c_sda(i2c_sda), .i2c_scl(i2c_scl)
    );

    // Slave side of the bus: open-drain pull-down plus weak pullup.
    logic slave_low = 1'b0;
    assign i2c_sda = slave_low ? 1'b0 : 1'bz;
    pullup pu_sda (i2c_sda);

    // Slave model and bus monitor, sampled once per clk away from the edge.
    typedef enum int {S_IDLE, S_ADDR, S_AACK, S_WDATA, S_WACK, S_RDATA, S_RACK} sph_t;
    sph_t       sph = S_IDLE;
    int         scnt = 0;
    logic [7:0] sbyte = '0;
    logic [7:0] stx = '0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [7:0] slave_reg = 8'h00;
    logic [7:0] mon_addr_byte = '0;
    logic [7:0] mon_wbyte = '0;
    logic       mon_master_nack = 1'b0;
    int         n_start = 0, n_stop = 0, n_addr = 0, n_wbytes = 0, n_rack = 0;

    always @(negedge clk) begin
        logic scl_s, sda_s;
        scl_s = i2c_scl;
        sda_s = i2c_sda;
        if (prev_scl && scl_s && prev_sda && !sda_s) begin
            n_start++; sph = S_ADDR; scnt = 0; slave_low = 1'b0;
        end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
            n_stop++; sph = S_IDLE; slave_low = 1'b0;
        end else if (!prev_scl && scl_s) begin
            case (sph)
                S_ADDR, S_WDATA: begin sbyte = {sbyte[6:0], sda_s}; scnt++; end
                S_RDATA: scnt++;
                S_RACK: begin mon_master_nack = sda_s; n_rack++; end
                default: ;
            endcase
        end else if (prev_scl && !scl_s) begin
            case (sph)
                S_ADDR: if (scnt == 8) begin
                    mon_addr_byte = sbyte; n_addr++;
                    if (sbyte[7:1] == SLAVE_ADDR) begin sph = S_AACK; slave_low = 1'b1; end
                    else sph = S_IDLE;
                end
                S_AACK: begin
                    scnt = 0;
                    if (sbyte[0]) begin sph = S_RDATA; stx = slave_reg; slave_low = !stx[7]; end
                    else begin sph = S_WDATA; slave_low = 1'b0; end
                end
                S_WDATA: if (scnt == 8) begin
                    slave_reg = sbyte; mon_wbyte = sbyte; n_wbytes++;
                    sph = S_WACK; slave_low = 1'b1;
                end
                S_WACK: begin slave_low = 1'b0; sph = S_IDLE; end
                S_RDATA: if (scnt == 8) begin slave_low = 1'b0; sph = S_RACK; end
                         else slave_low = !stx[7 - scnt];
                S_RACK: sph = S_IDLE;
                default: ;
            endcase
        end
        prev_scl = scl_s;
        prev_sda = sda_s;
    end

    // Transaction-level reference: slave register contents and last read byte.
    logic [7:0] model_reg  = 8'h00;
    logic [7:0] model_dout = 8'h00;

    task automatic model_step(input logic [6:0] a, input logic [7:0] d, input logic r,
                              output logic [7:0] exp_byte, output logic exp_ack,
                              output logic [7:0] exp_dout);
        exp_byte = {a, r};
        exp_ack  = (a == SLAVE_ADDR);
        exp_dout = (exp_ack && r) ? model_reg : model_dout;
        if (exp_ack && !r) model_reg = d;
        model_dout = exp_dout;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        n_tests++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // One request; returns clk edges from the enable-sampling edge until ready=1.
    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                           input int hold, output int busy);
        int cyc;
        @(posedge clk); #1;
        addr = a; data_in = d; rw = r; enable = 1'b1;
        cyc = 0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1; cyc++;
        end
        enable = 1'b0;
        addr = ~a; data_in = ~d; rw = ~r;
        while (!ready && cyc < TIMEOUT) begin @(posedge clk); #1; cyc++; end
        busy = cyc;
    endtask

    task automatic run_and_check(input string tag, input logic [6:0] a, input logic [7:0] d,
                                 input logic r, input int hold, input logic [7:0] exp_byte,
                                 input logic exp_ack, input logic [7:0] exp_dout);
        int s_start, s_stop, s_addr, s_w, s_rack, busy, f;
        s_start = n_start; s_stop = n_stop; s_addr = n_addr; s_w = n_wbytes; s_rack = n_rack;
        run_txn(a, d, r, hold, busy);
        f = (exp_ack ? 20 : 11) * 4 * CLK_DIV;
        check_range({tag, "_busy_cycles"}, busy, 2 + f, 1 + CLK_DIV + f);
        check({tag, "_ready"}, ready, 1);
        check({tag, "_starts"}, n_start - s_start, 1);
        check({tag, "_stops"}, n_stop - s_stop, 1);
        check({tag, "_addr_seen"}, n_addr - s_addr, 1);
        check({tag, "_addr_byte"}, mon_addr_byte, exp_byte);
        check({tag, "_data_out"}, data_out, exp_dout);
        if (exp_ack && !r) begin
            check({tag, "_wbytes"}, n_wbytes - s_w, 1);
            check({tag, "_slave_byte"}, mon_wbyte, d);
        end else begin
            check({tag, "_no_wbyte"}, n_wbytes - s_w, 0);
        end
        if (exp_ack && r) begin
            check({tag, "_nack_bits"}, n_rack - s_rack, 1);
            check({tag, "_master_nack"}, mon_master_nack, 1);
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
        logic       rw;
        int         hold;
        logic [7:0] exp_addr_byte;
        logic       exp_ack;
        logic [7:0] exp_dout;
    } vec_t;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [8];
        logic [7:0] eb, ed;
        logic       ea;
        int         cyc, gap, s_start, s_stop, s_w;
        logic [6:0] ra;
        logic [7:0] rd;
        logic       rr;

        vecs[0] = '{7'h2A, 8'hAA, 1'b0, 5, 8'h54, 1'b1, 8'h00};
        vecs[1] = '{7'h2A, 8'h00, 1'b1, 1, 8'h55, 1'b1, 8'hAA};
        vecs[2] = '{7'h15, 8'h5A, 1'b0, 1, 8'h2A, 1'b0, 8'hAA};
        vecs[3] = '{7'h2A, 8'h3C, 1'b0, 2, 8'h54, 1'b1, 8'hAA};
        vecs[4] = '{7'h2A, 8'hFF, 1'b1, 1, 8'h55, 1'b1, 8'h3C};
        vecs[5] = '{7'h15, 8'h00, 1'b1, 3, 8'h2B, 1'b0, 8'h3C};
        vecs[6] = '{7'h2A, 8'h81, 1'b0, 1, 8'h54, 1'b1, 8'h3C};
        vecs[7] = '{7'h2A, 8'h00, 1'b1, 1, 8'h55, 1'b1, 8'h81};

        // Reset values while rst is held, then released.
        #50;
        check("rst_ready", ready, 1);
        check("rst_scl", i2c_scl, 1);
        check("rst_sda", i2c_sda, 1);
        check("rst_data_out", data_out, 8'h00);
        #50;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_ready", ready, 1);

        for (int i = 0; i < 8; i++) begin
            model_step(vecs[i].addr, vecs[i].data, vecs[i].rw, eb, ea, ed);
            run_and_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].rw,
                          vecs[i].hold, vecs[i].exp_addr_byte, vecs[i].exp_ack,
                          vecs[i].exp_dout);
        end

        // Reset in the middle of the address byte.
        @(posedge clk); #1;
        addr = SLAVE_ADDR; data_in = 8'hC3; rw = 1'b0; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (CLK_DIV + 4 * CLK_DIV * 3) @(posedge clk);
        #1;
        check("midaddr_busy", ready, 0);
        rst = 1'b1;
        #1;
        check("midaddr_rst_ready", ready, 1);
        check("midaddr_rst_scl", i2c_scl, 1);
        check("midaddr_rst_sda", i2c_sda, 1);
        check("midaddr_rst_data_out", data_out, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        model_dout = 8'h00;
        repeat (4) @(posedge clk);
        model_step(SLAVE_ADDR, 8'h77, 1'b0, eb, ea, ed);
        run_and_check("after_rst_wr", SLAVE_ADDR, 8'h77, 1'b0, 1, eb, ea, ed);
        model_step(SLAVE_ADDR, 8'h00, 1'b1, eb, ea, ed);
        run_and_check("after_rst_rd", SLAVE_ADDR, 8'h00, 1'b1, 1, eb, ea, ed);

        // Enable held high across two frames.
        s_start = n_start; s_stop = n_stop; s_w = n_wbytes;
        @(posedge clk); #1;
        addr = SLAVE_ADDR; data_in = 8'h5E; rw = 1'b0; enable = 1'b1;
        cyc = 0;
        while (ready && cyc < TIMEOUT) begin @(posedge clk); #1; cyc++; end
        cyc = 0;
        while (!ready && cyc < TIMEOUT) begin @(posedge clk); #1; cyc++; end
        check("b2b_first_done", ready, 1);
        gap = 0;
        while (ready && gap < TIMEOUT) begin @(posedge clk); #1; gap++; end
        enable = 1'b0;
        check_range("b2b_ready_gap", gap, 1, CLK_DIV);
        cyc = 0;
        while (!ready && cyc < TIMEOUT) begin @(posedge clk); #1; cyc++; end
        check("b2b_second_done", ready, 1);
        check("b2b_starts", n_start - s_start, 2);
        check("b2b_stops", n_stop - s_stop, 2);
        check("b2b_wbytes", n_wbytes - s_w, 2);
        check("b2b_slave_reg", slave_reg, 8'h5E);
        model_reg = 8'h5E;

        // Randomized transactions against the reference model.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = SLAVE_ADDR;
                2:       ra = 7'h15;
                default: ra = 7'($urandom);
            endcase
            rd = 8'($urandom);
            rr = 1'($urandom);
            model_step(ra, rd, rr, eb, ea, ed);
            run_and_check($sformatf("rnd%0d", i), ra, rd, rr, $urandom_range(1, 4), eb, ea, ed);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
